// File: rtl/lm32_divider.sv
`default_nettype none
// ============================================================================
// Module      : lm32_divider
// Description : Multicycle radix-2 non-restoring integer divider for the LM32
//               execute stage. Produces quotient and remainder for signed or
//               unsigned operands using a start/done handshake. Supports
//               abort via kill_i and flags division by zero.
// Revision    : 1.0 - initial release
// ============================================================================
module lm32_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] operand_0,
  input  logic [WIDTH-1:0] operand_1,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FIXUP  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Iteration state
  logic [CNT_W-1:0] r_count;
  logic [WIDTH:0]   r_rem;     // signed partial remainder, one guard bit
  logic [WIDTH-1:0] r_quo;     // dividend shifts out, quotient bits shift in
  logic [WIDTH-1:0] r_div;     // divisor magnitude
  logic             r_neg_q;   // quotient must be negated at the end
  logic             r_neg_r;   // remainder must be negated at the end

  // Launch-time decode
  logic             w_launch;
  logic             w_div_zero;
  logic             w_neg_0;
  logic             w_neg_1;
  logic [WIDTH-1:0] w_abs_0;
  logic [WIDTH-1:0] w_abs_1;

  // Iteration / correction datapath
  logic [WIDTH:0]   w_div_ext;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_rem_step;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_quo_final;
  logic [WIDTH-1:0] w_rem_final;
  logic             w_write_result;

  // A start is only honoured in IDLE, and a same-cycle kill suppresses it.
  assign w_launch   = (r_state == S_IDLE) && start_i && !kill_i;
  assign w_div_zero = (operand_1 == '0);

  // Magnitudes are taken only for signed operation. Negating the most
  // negative value yields the same bit pattern, which read as unsigned is
  // exactly 2^(WIDTH-1), so no special case is needed.
  assign w_neg_0 = signed_i && operand_0[WIDTH-1];
  assign w_neg_1 = signed_i && operand_1[WIDTH-1];
  assign w_abs_0 = w_neg_0 ? ('0 - operand_0) : operand_0;
  assign w_abs_1 = w_neg_1 ? ('0 - operand_1) : operand_1;

  // One non-restoring step: shift the next dividend bit into the partial
  // remainder, then subtract the divisor if the remainder was non-negative
  // or add it back if it was negative. The arithmetic wraps in WIDTH+1 bits,
  // which is safe because the post-step magnitude is always below the divisor.
  assign w_div_ext  = {1'b0, r_div};
  assign w_shift    = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_rem_step = r_rem[WIDTH] ? (w_shift + w_div_ext) : (w_shift - w_div_ext);

  // A negative final partial remainder is one divisor too low; only the low
  // WIDTH bits of the corrected value are significant.
  assign w_rem_fix = r_rem[WIDTH] ? (r_rem[WIDTH-1:0] + r_div) : r_rem[WIDTH-1:0];

  // Apply the signs latched at launch (truncating division: the remainder
  // takes the dividend's sign).
  assign w_quo_final = r_neg_q ? ('0 - r_quo)     : r_quo;
  assign w_rem_final = r_neg_r ? ('0 - w_rem_fix) : w_rem_fix;

  // A killed FIXUP must leave the previously published results untouched.
  assign w_write_result = (r_state == S_FIXUP) && !kill_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_state_next = r_state;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_state_next = w_div_zero ? S_DONE : S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        busy_o = 1'b1;
        if (kill_i) begin
          w_state_next = S_IDLE;
        end else if (r_count == '0) begin
          w_state_next = S_FIXUP;
        end
      end
      S_FIXUP: begin
        busy_o       = 1'b1;
        w_state_next = kill_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done_o       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture at launch and one quotient bit per DIVIDE cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_launch) begin
      r_count <= C_CNT_INIT;
      r_rem   <= '0;
      r_quo   <= w_abs_0;
      r_div   <= w_abs_1;
      r_neg_q <= w_neg_0 ^ w_neg_1;
      r_neg_r <= w_neg_0;
    end else if (r_state == S_DIVIDE) begin
      r_rem <= w_rem_step;
      r_quo <= {r_quo[WIDTH-2:0], ~w_rem_step[WIDTH]};
      if (r_count != '0) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Result registers: written by the divide-by-zero shortcut or by FIXUP,
  // otherwise held so software sees the last completed operation
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else if (w_launch && w_div_zero) begin
      quotient_o    <= '0;
      remainder_o   <= operand_0;
      div_by_zero_o <= 1'b1;
    end else if (w_write_result) begin
      quotient_o    <= w_quo_final;
      remainder_o   <= w_rem_final;
      div_by_zero_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lm32_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lm32_divider
// Description : Scoreboard bench for lm32_divider. Stimulus pushes expected
//               results from an arithmetic reference model; a monitor pops
//               and compares whenever done_o is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lm32_divider;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             start_i = 1'b0;
  logic             kill_i = 1'b0;
  logic             signed_i = 1'b0;
  logic [WIDTH-1:0] operand_0 = '0;
  logic [WIDTH-1:0] operand_1 = '0;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_by_zero_o;

  lm32_divider #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .kill_i       (kill_i),
    .signed_i     (signed_i),
    .operand_0    (operand_0),
    .operand_1    (operand_1),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } exp_t;

  exp_t scb[$];
  int   checks   = 0;
  int   failures = 0;

  // Last results the DUT should be holding
  logic [WIDTH-1:0] last_q   = '0;
  logic [WIDTH-1:0] last_r   = '0;
  logic             last_dbz = 1'b0;

  // Reference: plain truncating arithmetic in 64 bits
  function automatic exp_t ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s);
    exp_t   e;
    longint sa;
    longint sd;
    longint lq;
    longint lr;
    if (b == '0) begin
      e.q = '0;
      e.r = a;
      e.dbz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      lq = sa / sd;
      lr = sa % sd;
      e.q = lq[WIDTH-1:0];
      e.r = lr[WIDTH-1:0];
      e.dbz = 1'b0;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented result is matched against the oldest expectation
  initial begin
    exp_t me;
    forever begin
      @(negedge clk_i);
      if (rst_n_i && done_o) begin
        if (scb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done_o=1 expected no result pending at %0t", $time);
        end else begin
          me = scb.pop_front();
          chk("quotient", quotient_o, me.q);
          chk("remainder", remainder_o, me.r);
          chk("div_by_zero", div_by_zero_o, me.dbz);
          last_q   = me.q;
          last_r   = me.r;
          last_dbz = me.dbz;
        end
      end
    end
  end

  // Issue one start pulse; edge k is the posedge that samples it
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input bit push);
    @(negedge clk_i);
    operand_0 = a;
    operand_1 = b;
    signed_i  = s;
    start_i   = 1'b1;
    if (push) scb.push_back(ref_div(a, b, s));
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  // Count sampled cycles until done_o, bounded; 0 latency means it never came
  task automatic wait_done(input int exp_lat, input int exp_busy);
    int n;
    int nb;
    n  = 0;
    nb = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_i);
      if (busy_o) nb++;
      if (done_o) begin
        n = i;
        break;
      end
    end
    chk("latency", n, exp_lat);
    chk("busy_cycles", nb, exp_busy);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    issue(a, b, s, 1'b1);
    if (b == '0) wait_done(1, 0);
    else         wait_done(WIDTH + 2, WIDTH + 1);
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rs;

    // Reset state
    #12;
    chk("reset_quotient", quotient_o, 0);
    chk("reset_remainder", remainder_o, 0);
    chk("reset_dbz", div_by_zero_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Directed arithmetic cases
    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(32'd5, 32'd0, 1'b0);
    run_op(32'd9, 32'd3, 1'b0);

    // Start during the DONE cycle is dropped
    operand_0 = 32'd1;
    operand_1 = 32'd1;
    start_i   = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(negedge clk_i);
    chk("start_in_done_ignored", busy_o, 0);

    // Start while busy is dropped; the original op completes on time
    issue(32'd1000, 32'd10, 1'b0, 1'b1);
    repeat (3) @(negedge clk_i);
    @(negedge clk_i);
    operand_0 = 32'd77;
    operand_1 = 32'd7;
    start_i   = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_done(WIDTH + 2 - 4, WIDTH + 1 - 4);

    // Kill in DIVIDE: back to IDLE, no result, outputs held
    issue(32'd123456, 32'd789, 1'b0, 1'b0);
    repeat (9) @(negedge clk_i);
    @(negedge clk_i);
    kill_i = 1'b1;
    @(posedge clk_i);
    #1 kill_i = 1'b0;
    @(negedge clk_i);
    chk("kill_busy", busy_o, 0);
    chk("kill_hold_q", quotient_o, last_q);
    chk("kill_hold_r", remainder_o, last_r);
    chk("kill_hold_dbz", div_by_zero_o, last_dbz);
    repeat (40) @(negedge clk_i);

    // Kill wins over a same-cycle start in IDLE
    operand_0 = 32'd50;
    operand_1 = 32'd5;
    kill_i    = 1'b1;
    start_i   = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i  = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("kill_beats_start", busy_o, 0);
    run_op(32'd50, 32'd5, 1'b0);

    // Asynchronous reset mid-operation
    issue(32'hDEAD_BEEF, 32'd3, 1'b1, 1'b0);
    repeat (20) @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    chk("midreset_quotient", quotient_o, 0);
    chk("midreset_remainder", remainder_o, 0);
    chk("midreset_dbz", div_by_zero_o, 0);
    chk("midreset_busy", busy_o, 0);
    chk("midreset_done", done_o, 0);
    last_q   = '0;
    last_r   = '0;
    last_dbz = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_op(32'd4000000000, 32'd3, 1'b0);

    // Randomized operands biased toward edge cases
    for (int i = 0; i < 1200; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = WIDTH'($urandom_range(1, 16));
        2: rb = ~WIDTH'($urandom_range(0, 15));
        3: ra = 32'h8000_0000;
        4: rb = 32'hFFFF_FFFF;
        5: ra = WIDTH'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(ra, rb, rs);
    end

    repeat (5) @(negedge clk_i);
    chk("scoreboard_empty", scb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
